// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of one SDRAM controller slave port.
// The granted master's command goes straight to the slave with no added latency.
// Read returns are routed back to their masters in issue order through an ID FIFO.
// Ports:
//   clk_clk, reset_reset                     clock, async active-high reset
//   m0_* / m1_*                              master command, waitrequest and read return
//   s_*                                      command to the controller, slave handshake and return
//   err_unexp_rdv                            sticky: read return seen with nothing outstanding
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic                  s_readdatavalid,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic                  err_unexp_rdv
);

    localparam int unsigned PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             id_mem [MAX_PEND];

    logic grant_valid, winner, sel_read, sel_write, sel_req;
    logic blocked, accept, push, pop, head_id;

    // Arbitration, command forwarding and next state
    always_comb begin
        state_d        = IDLE;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        grant_valid    = 1'b0;
        winner         = 1'b0;
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        // A stalled command keeps its owner; otherwise ties go to the master not served last
        if (state_q == BUSY) begin
            grant_valid = 1'b1;
            winner      = owner_q;
        end else if ((m0_read | m0_write) && (m1_read | m1_write)) begin
            grant_valid = 1'b1;
            winner      = ~last_grant_q;
        end else if (m0_read | m0_write) begin
            grant_valid = 1'b1;
            winner      = 1'b0;
        end else if (m1_read | m1_write) begin
            grant_valid = 1'b1;
            winner      = 1'b1;
        end

        sel_read  = winner ? m1_read  : m0_read;
        sel_write = winner ? m1_write : m0_write;
        sel_req   = grant_valid & (sel_read | sel_write);

        // Read-and-write together counts as a read; reads stall while the ID FIFO is full
        blocked = sel_read & (count_q == CNT_W'(MAX_PEND));
        s_read  = sel_req & sel_read & ~blocked;
        s_write = sel_req & sel_write & ~sel_read;
        accept  = sel_req & ~s_waitrequest & ~blocked;

        if (winner) begin
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end

        if (grant_valid && !winner) m0_waitrequest = s_waitrequest | blocked;
        if (grant_valid &&  winner) m1_waitrequest = s_waitrequest | blocked;

        if (sel_req) begin
            if (accept) begin
                last_grant_d = winner;
            end else begin
                state_d = BUSY;
                owner_d = winner;
            end
        end
    end

    // Read return routing: the FIFO head names the master that issued the oldest read
    assign push             = accept & sel_read;
    assign pop              = s_readdatavalid & (count_q != '0);
    assign head_id          = id_mem[rd_ptr_q];
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop &  head_id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    // Arbiter state, FIFO pointers and error flag
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_unexp_rdv <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (s_readdatavalid && (count_q == '0)) err_unexp_rdv <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read behind the write pointer
    always_ff @(posedge clk_clk) begin
        if (push) id_mem[wr_ptr_q] <= winner;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, meaning word address width of masters and slave.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_PEND, default 4, meaning the maximum number of outstanding reads (power of 2, 2..16).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, named clk_clk and reset_reset as the codebase does.
REQ-005 clk_clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset_reset  in  1  asynchronous active-high reset.
REQ-007 mN_address  in  ADDR_W  master N command address (N = 0, 1 throughout).
REQ-008 mN_read, mN_write  in  1  master N read / write strobes.
REQ-009 mN_writedata  in  DATA_W; mN_byteenable  in  DATA_W/8.
REQ-010 mN_waitrequest  out  1  master N command not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W; mN_readdatavalid  out  1  read return to master N.
REQ-012 s_address, s_read, s_write, s_writedata, s_byteenable  out  as master widths  command to SDRAM controller slave.
REQ-013 s_waitrequest, s_readdatavalid  in  1; s_readdata  in  DATA_W  slave handshake and read return.
REQ-014 err_unexp_rdv  out  1  sticky flag: s_readdatavalid seen with no read outstanding.

Function
REQ-015 States SHALL be IDLE and BUSY; BUSY records owner (0/1).
REQ-016 In IDLE, winner SHALL be chosen combinationally: single requester wins; both requesting -> master other than last_grant wins (round-robin).
REQ-017 The winner's command SHALL be forwarded to s_* in the same cycle (zero added latency); non-granted master's mN_waitrequest SHALL be 1.
REQ-018 Acceptance SHALL occur when the forwarded command has s_waitrequest=0 and is not blocked by REQ-021; on acceptance last_grant <= owner, state IDLE.
REQ-019 If the forwarded command is not accepted, state SHALL go BUSY(owner) and hold owner until acceptance, regardless of the other master (Avalon command stability).
REQ-020 Granted mN_waitrequest SHALL equal s_waitrequest OR read-block; s_read/s_write SHALL be 0 when no master is granted or read is blocked.
REQ-021 Read-block: a read SHALL NOT be forwarded while outstanding count == MAX_PEND, even if a return pops in the same cycle.
REQ-022 Each accepted read SHALL push owner ID into an in-order ID FIFO of depth MAX_PEND; writes SHALL NOT touch the FIFO.
REQ-023 Each s_readdatavalid SHALL pop the FIFO head and assert mHEAD_readdatavalid with s_readdata the same cycle (combinational route); other master's readdatavalid = 0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo MAX_PEND.
REQ-025 s_readdatavalid with empty FIFO SHALL be dropped (no mN_readdatavalid) and SHALL set err_unexp_rdv until reset.
REQ-026 mN_read and mN_write both asserted SHALL be treated as a read only.
REQ-027 mN_readdata SHALL carry s_readdata for both masters continuously; only readdatavalid is gated.

Reset
REQ-028 On reset_reset=1: state IDLE, last_grant=1 (m0 wins first tie), FIFO count/pointers 0, err_unexp_rdv=0; outputs follow REQ-017/020 combinationally.
REQ-029 Reset mid-operation SHALL discard all outstanding read IDs; returns arriving after reset SHALL follow REQ-025.

Verification
REQ-030 Both masters read every cycle, s_waitrequest=0 -> grants alternate m0,m1,m0,...; returns routed in issue order.
REQ-031 m1 write stalled 3 cycles by s_waitrequest, m0 reads meanwhile -> s_* holds m1 command stable 4 cycles, m0_waitrequest=1, then m0 granted.
REQ-032 MAX_PEND=4, m0 issues 5 reads, no returns -> 5th held (m0_waitrequest=1, s_read=0) until first s_readdatavalid, accepted next cycle.
REQ-033 Count=4 with pop and new read same cycle -> read blocked that cycle, accepted next; count stays 4.
REQ-034 s_readdatavalid with FIFO empty after reset -> no mN_readdatavalid, err_unexp_rdv=1 sticky.
REQ-035 Reset asserted with 2 reads outstanding -> count 0, m0 granted first on simultaneous requests after release.
